// File: rtl/simd_mac_lane_array.sv
// simd_mac_lane_array: sequenced SIMD multiply-accumulate array with NUM_LANES masked MAC lanes
//
// Ports:
//   CLK, RST               rising-edge clock, synchronous active-high reset
//   START, OPCODE, LEN,    vector command: 00 MAC, 01 SUM, 10 CLEAR, 11 reserved;
//   ACC_KEEP, LANE_MASK    sampled only on START while idle
//   BUSY                   high whenever a command is in flight
//   IN_VALID, IN_READY     operand beat handshake (ready only while consuming beats)
//   A_DATAIN, B_DATAIN     per-lane signed operands, lane i at [i*DATA_W +: DATA_W]
//   OUT_VALID, OUT_READY   result handshake towards the store unit
//   DATAOUT                per-lane accumulators, masked lanes and non-OUT states read 0
//   DONE, ERR              one-cycle completion pulse, ERR marks the reserved opcode
module simd_mac_lane_array #(
    parameter int NUM_LANES = 4,
    parameter int DATA_W    = 32,
    parameter int ACC_W     = 32,
    parameter int LEN_W     = 5
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           START,
    input  logic [1:0]                     OPCODE,
    input  logic [LEN_W-1:0]               LEN,
    input  logic                           ACC_KEEP,
    input  logic [NUM_LANES-1:0]           LANE_MASK,
    output logic                           BUSY,
    input  logic                           IN_VALID,
    output logic                           IN_READY,
    input  logic [NUM_LANES*DATA_W-1:0]    A_DATAIN,
    input  logic [NUM_LANES*DATA_W-1:0]    B_DATAIN,
    output logic                           OUT_VALID,
    input  logic                           OUT_READY,
    output logic [NUM_LANES*ACC_W-1:0]     DATAOUT,
    output logic                           DONE,
    output logic                           ERR
);

    typedef enum logic [1:0] {IDLE, RUN, OUT, FIN} state_t;

    // Products are formed at a width covering both the full product and the accumulator,
    // so slicing to ACC_W yields either truncation or sign extension as needed.
    localparam int PW = (ACC_W > 2*DATA_W) ? ACC_W : 2*DATA_W;

    state_t               state, state_nx;
    logic [1:0]           op;
    logic [LEN_W-1:0]     len;
    logic [LEN_W-1:0]     cnt;
    logic [NUM_LANES-1:0] mask;
    logic [ACC_W-1:0]     acc    [NUM_LANES];
    logic [ACC_W-1:0]     addend [NUM_LANES];
    logic                 beat;
    logic                 take;

    assign take      = (state == IDLE) && START;
    assign beat      = (state == RUN) && IN_VALID;
    assign BUSY      = state != IDLE;
    assign IN_READY  = state == RUN;
    assign OUT_VALID = state == OUT;
    assign DONE      = state == FIN;
    assign ERR       = (state == FIN) && (op == 2'b11);

    genvar i;
    for (i = 0; i < NUM_LANES; i++) begin : g_lane
        logic signed [PW-1:0] a_ext, b_ext, prod;
        assign a_ext     = PW'($signed(A_DATAIN[i*DATA_W +: DATA_W]));
        assign b_ext     = PW'($signed(B_DATAIN[i*DATA_W +: DATA_W]));
        assign prod      = a_ext * b_ext;
        assign addend[i] = op[0] ? a_ext[ACC_W-1:0] : prod[ACC_W-1:0];
        assign DATAOUT[i*ACC_W +: ACC_W] = (state == OUT && mask[i]) ? acc[i] : '0;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (START) state_nx = OPCODE[1] ? FIN : (LEN == '0 ? OUT : RUN);
            RUN:  if (beat && cnt == len - LEN_W'(1)) state_nx = OUT;
            OUT:  if (OUT_READY) state_nx = FIN;
            FIN:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            op    <= '0;
            len   <= '0;
            cnt   <= '0;
            mask  <= '0;
            for (int k = 0; k < NUM_LANES; k++) acc[k] <= '0;
        end else begin
            state <= state_nx;
            if (take) begin
                op   <= OPCODE;
                len  <= LEN;
                mask <= LANE_MASK;
                cnt  <= '0;
                // CLEAR always zeroes; MAC/SUM zero unless chaining; reserved leaves them alone.
                if (OPCODE == 2'b10 || (!OPCODE[1] && !ACC_KEEP))
                    for (int k = 0; k < NUM_LANES; k++) acc[k] <= '0;
            end
            if (beat) begin
                cnt <= cnt + LEN_W'(1);
                for (int k = 0; k < NUM_LANES; k++)
                    if (mask[k]) acc[k] <= acc[k] + addend[k];
            end
        end
    end

endmodule

// File: tb/tb_simd_mac_lane_array.sv
// tb_simd_mac_lane_array: directed self-checking bench for simd_mac_lane_array
module tb_simd_mac_lane_array;

    localparam int NL = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int LW = 5;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic            START = 1'b0;
    logic [1:0]      OPCODE = '0;
    logic [LW-1:0]   LEN = '0;
    logic            ACC_KEEP = 1'b0;
    logic [NL-1:0]   LANE_MASK = '0;
    logic            BUSY;
    logic            IN_VALID = 1'b0;
    logic            IN_READY;
    logic [NL*DW-1:0] A_DATAIN = '0;
    logic [NL*DW-1:0] B_DATAIN = '0;
    logic            OUT_VALID;
    logic            OUT_READY = 1'b0;
    logic [NL*AW-1:0] DATAOUT;
    logic            DONE;
    logic            ERR;

    int n_chk  = 0;
    int n_fail = 0;

    simd_mac_lane_array #(.NUM_LANES(NL), .DATA_W(DW), .ACC_W(AW), .LEN_W(LW)) dut (
        .CLK(CLK), .RST(RST), .START(START), .OPCODE(OPCODE), .LEN(LEN),
        .ACC_KEEP(ACC_KEEP), .LANE_MASK(LANE_MASK), .BUSY(BUSY),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .A_DATAIN(A_DATAIN), .B_DATAIN(B_DATAIN),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .DATAOUT(DATAOUT),
        .DONE(DONE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    function automatic logic [127:0] v(input logic [31:0] l3, l2, l1, l0);
        return {l3, l2, l1, l0};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic [1:0] op, input logic [LW-1:0] len, input logic keep,
                       input logic [NL-1:0] mask);
        START = 1'b1; OPCODE = op; LEN = len; ACC_KEEP = keep; LANE_MASK = mask;
        @(negedge CLK);
        START = 1'b0; OPCODE = '0; LEN = '0; ACC_KEEP = 1'b0; LANE_MASK = '0;
    endtask

    task automatic beat(input logic [127:0] a, input logic [127:0] b);
        IN_VALID = 1'b1; A_DATAIN = a; B_DATAIN = b;
        @(negedge CLK);
        IN_VALID = 1'b0; A_DATAIN = '1; B_DATAIN = '1;
    endtask

    task automatic gap(input string tag);
        repeat (2) begin
            @(negedge CLK);
            chk(tag, {IN_READY, OUT_VALID}, 2'b10);
        end
    endtask

    task automatic finish_out(input string tag);
        OUT_READY = 1'b1;
        @(negedge CLK);
        OUT_READY = 1'b0;
        chk(tag, {DONE, ERR, OUT_VALID, BUSY}, 4'b1001);
        @(negedge CLK);
        chk({tag, "_idle"}, {DONE, BUSY}, 2'b00);
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        chk("reset_ctl", {BUSY, IN_READY, OUT_VALID, DONE, ERR}, 5'b0);
        chk("reset_data", DATAOUT, '0);

        // MAC LEN=3, full mask, with 2-cycle stalls between beats
        cmd(2'b00, 5'd3, 1'b0, 4'hF);
        chk("mac_run", {BUSY, IN_READY, OUT_VALID}, 3'b110);
        beat(v(65536, 0, -2, 1), v(65536, 9, 3, 4));
        gap("mac_gap1");
        beat(v(1, 0, -2, 2), v(7, 9, 3, 5));
        gap("mac_gap2");
        beat(v(1, 0, -2, 3), v(-1, 9, 3, 6));
        chk("mac_out_valid", {OUT_VALID, IN_READY}, 2'b10);
        chk("mac_data", DATAOUT, v(6, 0, -18, 32));
        START = 1'b1; OPCODE = 2'b10; LEN = 5'd0; LANE_MASK = 4'hF;
        @(negedge CLK);
        START = 1'b0; OPCODE = '0; LANE_MASK = '0;
        chk("mac_hold", {OUT_VALID, BUSY, DONE}, 3'b110);
        chk("mac_hold_data", DATAOUT, v(6, 0, -18, 32));
        OUT_READY = 1'b1;
        @(negedge CLK);
        OUT_READY = 1'b0;
        chk("mac_done", {DONE, ERR, OUT_VALID, IN_READY}, 4'b1000);
        chk("mac_done_data", DATAOUT, '0);
        @(negedge CLK);
        chk("mac_idle", {DONE, BUSY}, 2'b00);

        // Chained MAC continuing from the previous accumulators
        cmd(2'b00, 5'd1, 1'b1, 4'hF);
        beat(v(2, 2, 2, 2), v(2, 2, 2, 2));
        chk("keep_data", DATAOUT, v(10, 4, -14, 36));
        finish_out("keep_done");

        // CLEAR then an empty SUM that only reads back
        cmd(2'b10, 5'd0, 1'b0, 4'hF);
        chk("clear_done", {DONE, ERR, BUSY}, 3'b101);
        @(negedge CLK);
        cmd(2'b01, 5'd0, 1'b1, 4'hF);
        chk("len0_valid", OUT_VALID, 1'b1);
        chk("clear_data", DATAOUT, '0);
        finish_out("len0_done");

        // Masked SUM with zero-wait store handshake
        cmd(2'b01, 5'd2, 1'b0, 4'b0101);
        beat(v(7, 7, 7, 7), v(1, 1, 1, 1));
        beat(v(-3, -3, -3, -3), v(5, 5, 5, 5));
        OUT_READY = 1'b1;
        chk("mask_valid", OUT_VALID, 1'b1);
        chk("mask_data", DATAOUT, v(0, 4, 0, 4));
        @(negedge CLK);
        OUT_READY = 1'b0;
        chk("mask_done", {DONE, OUT_VALID}, 2'b10);
        @(negedge CLK);

        // Two's-complement wrap of the accumulator
        cmd(2'b01, 5'd2, 1'b0, 4'b0001);
        beat(v(0, 0, 0, 32'h7FFF_FFFF), '0);
        beat(v(0, 0, 0, 1), '0);
        chk("ovf_data", DATAOUT, v(0, 0, 0, 32'h8000_0000));
        finish_out("ovf_done");

        // Reserved opcode: DONE+ERR pulse, accumulators untouched
        cmd(2'b11, 5'd4, 1'b0, 4'hF);
        chk("rsv_pulse", {DONE, ERR, BUSY, IN_READY}, 4'b1110);
        @(negedge CLK);
        chk("rsv_clear", {DONE, ERR, BUSY}, 3'b000);
        cmd(2'b01, 5'd0, 1'b1, 4'hF);
        chk("rsv_acc", DATAOUT, v(0, 0, 0, 32'h8000_0000));
        finish_out("rsv_done");

        // Reset in the middle of a RUN
        cmd(2'b00, 5'd3, 1'b0, 4'hF);
        beat(v(1, 1, 1, 1), v(1, 1, 1, 1));
        RST = 1'b1;
        @(negedge CLK);
        chk("rst_ctl", {BUSY, IN_READY, OUT_VALID, DONE, ERR}, 5'b0);
        chk("rst_data", DATAOUT, '0);
        RST = 1'b0;
        cmd(2'b01, 5'd0, 1'b1, 4'hF);
        chk("rst_acc", DATAOUT, '0);
        finish_out("rst_done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
